// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter: merges I-cache refills and D-cache refills/write-backs
// onto the single line-request port of the cache-line AXI master. The
// winning request is latched, held stable for the whole master transaction,
// and the master's completion is returned to the owner as a one-cycle grant
// that carries the registered line.
module cache_axi_arbiter #(
    parameter int LINE_ADDR_LEN = 3
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    // I-cache client (read-only)
    input  logic                                 i_rd_req,
    input  logic [31:0]                          i_addr,
    output logic                                 i_gnt,
    output logic [(2**LINE_ADDR_LEN)-1:0][31:0]  i_rd_line,
    // D-cache client (refill and write-back)
    input  logic                                 d_rd_req,
    input  logic                                 d_wr_req,
    input  logic [31:0]                          d_addr,
    input  logic [(2**LINE_ADDR_LEN)-1:0][31:0]  d_wr_line,
    output logic                                 d_gnt,
    output logic [(2**LINE_ADDR_LEN)-1:0][31:0]  d_rd_line,
    // AXI master line-request port
    input  logic                                 m_gnt,
    input  logic [(2**LINE_ADDR_LEN)-1:0][31:0]  m_rd_line,
    output logic [31:0]                          m_addr,
    output logic                                 m_rd_req,
    output logic                                 m_wr_req,
    output logic [(2**LINE_ADDR_LEN)-1:0][31:0]  m_wr_line
);

    localparam int WORDS = 2**LINE_ADDR_LEN;

    // Byte-offset bits within one line: word offset plus 2 byte-select bits.
    localparam logic [31:0] LINE_OFFSET_MASK = (32'd1 << (LINE_ADDR_LEN + 2)) - 32'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e                   state_q;
    logic                     last_i_q;
    logic                     i_gnt_q;
    logic                     d_gnt_q;
    logic                     m_rd_req_q;
    logic                     m_wr_req_q;
    logic [31:0]              m_addr_q;
    logic [WORDS-1:0][31:0]   m_wr_line_q;
    logic [WORDS-1:0][31:0]   i_rd_line_q;
    logic [WORDS-1:0][31:0]   d_rd_line_q;

    logic                     d_any_req_s;
    logic                     d_wins_s;

    // Clear the within-line offset so the master always sees a line address.
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & ~LINE_OFFSET_MASK;
    endfunction

    // A D request of either kind competes; D wins alone, or on a tie when I won last.
    always_comb begin
        d_any_req_s = d_rd_req | d_wr_req;
        d_wins_s    = d_any_req_s & (~i_rd_req | last_i_q);
    end

    // Arbitration FSM with all client and master outputs registered.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            last_i_q    <= 1'b1;
            i_gnt_q     <= 1'b0;
            d_gnt_q     <= 1'b0;
            m_rd_req_q  <= 1'b0;
            m_wr_req_q  <= 1'b0;
            m_addr_q    <= 32'd0;
            m_wr_line_q <= '0;
            i_rd_line_q <= '0;
            d_rd_line_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (d_wins_s) begin
                        // A simultaneous rd+wr from D is a write-back.
                        state_q     <= BUSY_D;
                        last_i_q    <= 1'b0;
                        m_addr_q    <= line_align(d_addr);
                        m_wr_req_q  <= d_wr_req;
                        m_rd_req_q  <= ~d_wr_req;
                        m_wr_line_q <= d_wr_req ? d_wr_line : '0;
                    end else if (i_rd_req) begin
                        state_q     <= BUSY_I;
                        last_i_q    <= 1'b1;
                        m_addr_q    <= line_align(i_addr);
                        m_wr_req_q  <= 1'b0;
                        m_rd_req_q  <= 1'b1;
                        m_wr_line_q <= '0;
                    end else begin
                        // Nothing requested; a stray m_gnt here is ignored.
                        state_q     <= IDLE;
                    end
                end
                BUSY_I: begin
                    if (m_gnt) begin
                        i_rd_line_q <= m_rd_line;
                        i_gnt_q     <= 1'b1;
                        m_rd_req_q  <= 1'b0;
                        m_wr_req_q  <= 1'b0;
                        state_q     <= RESP;
                    end else begin
                        state_q     <= BUSY_I;
                    end
                end
                BUSY_D: begin
                    if (m_gnt) begin
                        // Write-backs leave the D refill bank untouched.
                        if (!m_wr_req_q) begin
                            d_rd_line_q <= m_rd_line;
                        end else begin
                            d_rd_line_q <= d_rd_line_q;
                        end
                        d_gnt_q     <= 1'b1;
                        m_rd_req_q  <= 1'b0;
                        m_wr_req_q  <= 1'b0;
                        state_q     <= RESP;
                    end else begin
                        state_q     <= BUSY_D;
                    end
                end
                RESP: begin
                    i_gnt_q <= 1'b0;
                    d_gnt_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    i_gnt_q    <= 1'b0;
                    d_gnt_q    <= 1'b0;
                    m_rd_req_q <= 1'b0;
                    m_wr_req_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign i_gnt     = i_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign i_rd_line = i_rd_line_q;
    assign d_rd_line = d_rd_line_q;
    assign m_addr    = m_addr_q;
    assign m_rd_req  = m_rd_req_q;
    assign m_wr_req  = m_wr_req_q;
    assign m_wr_line = m_wr_line_q;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Randomized self-checking bench for cache_axi_arbiter. A transaction-level
// model tracks which clients are pending, the round-robin preference and the
// contents of both refill banks, and predicts every master-side and
// client-side value from those.
module tb_cache_axi_arbiter;

    localparam int W = 8;

    logic                 aclk = 1'b0;
    logic                 aresetn = 1'b0;
    logic                 i_rd_req = 1'b0;
    logic [31:0]          i_addr = 32'd0;
    logic                 i_gnt;
    logic [W-1:0][31:0]   i_rd_line;
    logic                 d_rd_req = 1'b0;
    logic                 d_wr_req = 1'b0;
    logic [31:0]          d_addr = 32'd0;
    logic [W-1:0][31:0]   d_wr_line = '0;
    logic                 d_gnt;
    logic [W-1:0][31:0]   d_rd_line;
    logic                 m_gnt = 1'b0;
    logic [W-1:0][31:0]   m_rd_line = '0;
    logic [31:0]          m_addr;
    logic                 m_rd_req;
    logic                 m_wr_req;
    logic [W-1:0][31:0]   m_wr_line;

    always #5 aclk = ~aclk;

    cache_axi_arbiter #(.LINE_ADDR_LEN(3)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .i_rd_req  (i_rd_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rd_line (i_rd_line),
        .d_rd_req  (d_rd_req),
        .d_wr_req  (d_wr_req),
        .d_addr    (d_addr),
        .d_wr_line (d_wr_line),
        .d_gnt     (d_gnt),
        .d_rd_line (d_rd_line),
        .m_gnt     (m_gnt),
        .m_rd_line (m_rd_line),
        .m_addr    (m_addr),
        .m_rd_req  (m_rd_req),
        .m_wr_req  (m_wr_req),
        .m_wr_line (m_wr_line)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit                 mdl_last_i;
    bit                 i_pend;
    bit                 d_pend;
    logic [W-1:0][31:0] mdl_i_line;
    logic [W-1:0][31:0] mdl_d_line;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0][31:0] rand_line();
        logic [W-1:0][31:0] r;
        for (int k = 0; k < W; k++) r[k] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        mdl_last_i = 1'b1;
        i_pend     = 1'b0;
        d_pend     = 1'b0;
        mdl_i_line = '0;
        mdl_d_line = '0;
    endtask

    task automatic idle_checks(input string where);
        check_val({where, ".m_rd_req"}, m_rd_req, 1'b0);
        check_val({where, ".m_wr_req"}, m_wr_req, 1'b0);
        check_val({where, ".i_gnt"}, i_gnt, 1'b0);
        check_val({where, ".d_gnt"}, d_gnt, 1'b0);
        check_val({where, ".i_rd_line"}, i_rd_line, mdl_i_line);
        check_val({where, ".d_rd_line"}, d_rd_line, mdl_d_line);
    endtask

    // One arbitration opportunity; entered and left on a negedge with the DUT idle.
    task automatic run_round(input bit fi, input bit fd, input bit rnd);
        bit                 want_i;
        bit                 want_d;
        bit                 serve_d;
        bit                 exp_wr;
        int                 kind;
        int                 lat;
        logic [31:0]        exp_addr;
        logic [W-1:0][31:0] exp_wline;
        logic [W-1:0][31:0] mline;

        want_i = fi || (rnd && ($urandom_range(0, 2) == 0));
        want_d = fd || (rnd && ($urandom_range(0, 2) == 0));
        if (!i_pend && want_i) begin
            i_pend   = 1'b1;
            i_rd_req = 1'b1;
            i_addr   = $urandom;
        end
        if (!d_pend && want_d) begin
            d_pend    = 1'b1;
            kind      = $urandom_range(0, 2);
            d_rd_req  = (kind != 1);
            d_wr_req  = (kind != 0);
            d_addr    = $urandom;
            d_wr_line = rand_line();
        end
        if (!i_pend && !d_pend && ($urandom_range(0, 3) == 0)) begin
            m_gnt     = 1'b1;
            m_rd_line = rand_line();
        end
        @(negedge aclk);
        m_gnt = 1'b0;

        if (!i_pend && !d_pend) begin
            idle_checks("idle");
            return;
        end

        serve_d    = d_pend && (!i_pend || mdl_last_i);
        mdl_last_i = !serve_d;
        exp_addr   = (serve_d ? d_addr : i_addr) & 32'hFFFF_FFE0;
        exp_wr     = serve_d && d_wr_req;
        exp_wline  = exp_wr ? d_wr_line : '0;
        lat        = $urandom_range(0, 3);
        mline      = rand_line();

        for (int c = 0; c <= lat; c++) begin
            check_val("busy.m_addr", m_addr, exp_addr);
            check_val("busy.m_rd_req", m_rd_req, !exp_wr);
            check_val("busy.m_wr_req", m_wr_req, exp_wr);
            check_val("busy.m_wr_line", m_wr_line, exp_wline);
            check_val("busy.i_gnt", i_gnt, 1'b0);
            check_val("busy.d_gnt", d_gnt, 1'b0);
            if (c == lat) begin
                m_gnt     = 1'b1;
                m_rd_line = mline;
            end
            @(negedge aclk);
        end
        m_gnt = 1'b0;

        if (!exp_wr) begin
            if (serve_d) mdl_d_line = mline;
            else         mdl_i_line = mline;
        end
        check_val("resp.i_gnt", i_gnt, !serve_d);
        check_val("resp.d_gnt", d_gnt, serve_d);
        check_val("resp.m_rd_req", m_rd_req, 1'b0);
        check_val("resp.m_wr_req", m_wr_req, 1'b0);
        check_val("resp.i_rd_line", i_rd_line, mdl_i_line);
        check_val("resp.d_rd_line", d_rd_line, mdl_d_line);

        if (serve_d) begin
            d_rd_req = 1'b0;
            d_wr_req = 1'b0;
            d_pend   = 1'b0;
        end else begin
            i_rd_req = 1'b0;
            i_pend   = 1'b0;
        end
        @(negedge aclk);
        idle_checks("post");
    endtask

    task automatic drain();
        for (int k = 0; k < 4; k++) begin
            if (i_pend || d_pend) run_round(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic check_all_zero(input string where);
        check_val({where, ".i_gnt"}, i_gnt, 1'b0);
        check_val({where, ".d_gnt"}, d_gnt, 1'b0);
        check_val({where, ".m_rd_req"}, m_rd_req, 1'b0);
        check_val({where, ".m_wr_req"}, m_wr_req, 1'b0);
        check_val({where, ".m_addr"}, m_addr, 32'd0);
        check_val({where, ".m_wr_line"}, m_wr_line, 256'd0);
        check_val({where, ".i_rd_line"}, i_rd_line, 256'd0);
        check_val({where, ".d_rd_line"}, d_rd_line, 256'd0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge aclk);
        check_all_zero("reset");
        aresetn = 1'b1;
        @(negedge aclk);
        idle_checks("after_reset");

        // Tie right after reset: D first, then I, then the next tie goes to D.
        run_round(1'b1, 1'b1, 1'b0);
        run_round(1'b0, 1'b0, 1'b0);
        run_round(1'b1, 1'b1, 1'b0);
        drain();

        for (int r = 0; r < 150; r++) run_round(1'b0, 1'b0, 1'b1);
        drain();

        // Reset while BUSY_D with the master completion arriving.
        d_rd_req = 1'b1;
        d_wr_req = 1'b0;
        d_addr   = 32'h0000_5678;
        @(negedge aclk);
        check_val("rst.busy_rd_req", m_rd_req, 1'b1);
        check_val("rst.busy_addr", m_addr, 32'h0000_5660);
        m_gnt     = 1'b1;
        m_rd_line = rand_line();
        aresetn   = 1'b0;
        @(negedge aclk);
        check_all_zero("mid_reset");
        m_gnt    = 1'b0;
        d_rd_req = 1'b0;
        @(negedge aclk);
        check_all_zero("mid_reset2");
        aresetn = 1'b1;
        model_reset();
        @(negedge aclk);
        idle_checks("rst_release");

        run_round(1'b1, 1'b0, 1'b0);
        for (int r = 0; r < 40; r++) run_round(1'b0, 1'b0, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_axi_arbiter.md
# cache_axi_arbiter

Two-client arbiter that sits directly upstream of the cache-line AXI master. It merges instruction-cache refills (read-only) and data-cache refills/write-backs into the AXI master's single line-request port. Each client request is latched and presented to the AXI master with a line-aligned address, stable data and one request type. The master's completion is routed back to the owning client as a one-cycle grant with the registered 8-word line.

## Interface
- LINE_ADDR_LEN, 3, log2 of words per line; line = 2^LINE_ADDR_LEN 32-bit words (8).
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  reset, synchronous, active-low.
- i_rd_req  in  1  I-cache line read request.
- i_addr  in  32  I-cache request address.
- i_gnt  out  1  one-cycle completion pulse to I-cache.
- i_rd_line  out  32 x 8  refill line to I-cache; valid while i_gnt=1.
- d_rd_req  in  1  D-cache line read request.
- d_wr_req  in  1  D-cache line write-back request.
- d_addr  in  32  D-cache request address.
- d_wr_line  in  32 x 8  D-cache write-back line.
- d_gnt  out  1  one-cycle completion pulse to D-cache.
- d_rd_line  out  32 x 8  refill line to D-cache; valid while d_gnt=1.
- m_gnt  in  1  completion pulse from the AXI master.
- m_rd_line  in  32 x 8  read line from the AXI master; valid while m_gnt=1.
- m_addr  out  32  line-aligned request address to the AXI master.
- m_rd_req  out  1  read request to the AXI master.
- m_wr_req  out  1  write request to the AXI master.
- m_wr_line  out  32 x 8  write line to the AXI master.

## Operation
- Client protocol: hold req, address and write line stable until the gnt cycle. Deassert req on the cycle after gnt.
- States: IDLE, BUSY_I, BUSY_D, RESP. Reset state is IDLE.
- IDLE, no request: stay in IDLE.
- IDLE, exactly one client requesting: go to that client's BUSY state.
- IDLE, both clients requesting: round-robin on flag last_i.
  - last_i=1: D wins, and last_i is cleared.
  - last_i=0: I wins, and last_i is set.
  - last_i reset value is 1, so D wins the first tie.
- Winning a single-client request also updates last_i to match the winner.
- On the IDLE->BUSY edge, latch the winner's request:
  - req_addr = addr with bits [LINE_ADDR_LEN+1:0] cleared.
  - req_wr = 1 only for D with d_wr_req=1. If d_rd_req and d_wr_req are both 1, it is treated as a write.
  - req_line = d_wr_line, or zeros for reads.
- BUSY_x outputs: m_addr=req_addr, m_wr_line=req_line, m_wr_req=req_wr, m_rd_req=!req_wr.
- BUSY_x on m_gnt=1:
  - capture m_rd_line into the owner's rd_line register (reads only; writes leave it unchanged);
  - go to RESP.
- BUSY_x on m_gnt=0: stay in BUSY_x.
- RESP: assert the owner's gnt (i_gnt or d_gnt) for exactly one cycle, then go to IDLE.
- In IDLE and RESP, m_rd_req=m_wr_req=0. The master must see req low the cycle after its gnt, so that it does not restart.
- m_gnt outside BUSY_x: ignored.
- Reset values:
  - all outputs 0 (gnts, m_rd_req, m_wr_req, m_addr, m_wr_line, both rd_line banks);
  - state IDLE, last_i=1.
- Reset mid-transaction: abandon the transaction and return to IDLE on the reset edge. No gnt is issued. The AXI master shares aresetn and is reset in the same cycle.

## Timing
- Cycle t0: request high in IDLE. At t1: BUSY, m_*_req=1, m_addr valid.
- m_gnt at cycle tn: RESP at tn+1, client gnt=1 and rd_line valid. IDLE at tn+2.
- Added latency vs. a direct connection: +1 cycle at start, +1 cycle at end.
- Back-to-back: the next transaction can be in BUSY at tn+3 at the earliest.
- m_addr, m_wr_line and the m_*_req outputs are constant for the whole BUSY interval.
- Client gnt is never asserted in the same cycle as m_gnt.

## Test plan
- I-cache read only:
  - stimulus: i_addr=0x1FC0_0014, master returns words 0..7 = 0xA0..0xA7;
  - required: m_addr=0x1FC0_0000, m_rd_req=1 from t1, i_gnt pulses once at m_gnt+1, i_rd_line[k]=0xA0+k, d_gnt stays 0.
- D-cache write-back:
  - stimulus: d_wr_req=1, d_addr=0x0000_1234, d_wr_line[k]=k;
  - required: m_wr_req=1, m_rd_req=0, m_addr=0x0000_1220, m_wr_line[k]=k stable until m_gnt, d_gnt pulses once, d_rd_line unchanged.
- Simultaneous requests right after reset:
  - required: D is served first, then I; after both are served, the next tie goes to D again.
- d_rd_req=d_wr_req=1 together: serviced as a write, m_rd_req=0 throughout.
- aresetn=0 while BUSY_D with m_gnt pending:
  - required: next cycle all outputs are 0, state is IDLE, no d_gnt;
  - after reset release, a new i_rd_req is serviced normally.
- Stray m_gnt in IDLE: no gnt to either client and no state change.
